// File: rtl/int_ctrl.sv
// Memory-mapped interrupt controller: sticky edge/level pending bits, a mask,
// a registered intq bus to the CPU and a lowest-index-first vector register.
module int_ctrl #(
  parameter int          N_SRC      = 6,
  parameter logic [5:0]  RESET_MASK = 6'h00,
  parameter logic [5:0]  RESET_MODE = 6'h3F
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:2]       addr,
  input  logic             we,
  input  logic [31:0]      din,
  output logic [31:0]      dout,
  input  logic [N_SRC-1:0] irq_in,
  output logic [5:0]       intq,
  output logic             irq_any
);

  localparam logic [1:0] A_IMR  = 2'b00;
  localparam logic [1:0] A_IPR  = 2'b01;
  localparam logic [1:0] A_MODE = 2'b10;
  localparam logic [1:0] A_VEC  = 2'b11;

  logic [N_SRC-1:0] imr_q, imr_d;
  logic [N_SRC-1:0] mode_q, mode_d;
  logic [N_SRC-1:0] ipr_q, ipr_d;
  logic [N_SRC-1:0] irq_q, irq_d;
  logic [5:0]       intq_q, intq_d;
  logic             irq_any_q, irq_any_d;

  logic [N_SRC-1:0] pend;
  logic [N_SRC-1:0] w1c;
  logic [2:0]       vec_idx;
  logic [31:0]      vec_word;

  assign pend = ipr_q & imr_q;
  assign w1c  = (we && addr == A_IPR) ? din[N_SRC-1:0] : '0;

  always_comb begin
    imr_d  = imr_q;
    mode_d = mode_q;
    if (we && addr == A_IMR)  imr_d  = din[N_SRC-1:0];
    if (we && addr == A_MODE) mode_d = din[N_SRC-1:0];
    irq_d = irq_in;
  end

  // Mode takes effect from the edge after it is written; a new edge beats a same-cycle clear.
  always_comb begin
    ipr_d = ipr_q;
    for (int i = 0; i < N_SRC; i++) begin
      if (mode_q[i])
        ipr_d[i] = (irq_in[i] & ~irq_q[i]) | (ipr_q[i] & ~w1c[i]);
      else
        ipr_d[i] = irq_in[i];
    end
  end

  always_comb begin
    intq_d              = '0;
    intq_d[N_SRC-1:0]   = pend;
    irq_any_d           = |pend;
  end

  // Descending scan so the lowest pending index is the one left in vec_idx.
  always_comb begin
    vec_idx = 3'd0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (pend[i]) vec_idx = 3'(i);
    end
    vec_word      = '0;
    vec_word[31]  = |pend;
    vec_word[2:0] = vec_idx;
  end

  always_comb begin
    dout = '0;
    case (addr)
      A_IMR:   dout[N_SRC-1:0] = imr_q;
      A_IPR:   dout[N_SRC-1:0] = ipr_q;
      A_MODE:  dout[N_SRC-1:0] = mode_q;
      A_VEC:   dout            = vec_word;
      default: dout            = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      imr_q     <= RESET_MASK[N_SRC-1:0];
      mode_q    <= RESET_MODE[N_SRC-1:0];
      ipr_q     <= '0;
      irq_q     <= '0;
      intq_q    <= '0;
      irq_any_q <= 1'b0;
    end else begin
      imr_q     <= imr_d;
      mode_q    <= mode_d;
      ipr_q     <= ipr_d;
      irq_q     <= irq_d;
      intq_q    <= intq_d;
      irq_any_q <= irq_any_d;
    end
  end

  assign intq    = intq_q;
  assign irq_any = irq_any_q;

endmodule

// File: tb/tb_int_ctrl.sv
// Directed bench for int_ctrl: reset defaults, edge/level latching, masking,
// set-beats-clear, priority vector and mid-operation reset.
module tb_int_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:2]  addr;
  logic        we;
  logic [31:0] din;
  logic [31:0] dout;
  logic [5:0]  irq_in;
  logic [5:0]  intq;
  logic        irq_any;

  int total = 0;
  int bad   = 0;

  int_ctrl #(.N_SRC(6), .RESET_MASK(6'h00), .RESET_MODE(6'h3F)) dut (
    .clk     (clk),
    .reset   (reset),
    .addr    (addr),
    .we      (we),
    .din     (din),
    .dout    (dout),
    .irq_in  (irq_in),
    .intq    (intq),
    .irq_any (irq_any)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
    end else begin
      $display("ok   %s: %08h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    addr = a;
    din  = d;
    we   = 1'b1;
    step();
    we   = 1'b0;
    din  = '0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] v);
    addr = a;
    #1;
    v = dout;
  endtask

  logic [31:0] v;

  initial begin
    // reset held with a pending write and all lines high
    reset = 1'b0; we = 1'b1; din = 32'hFFFF_FFFF; addr = 2'b00; irq_in = 6'h3F;
    step(); step();
    reset = 1'b1; we = 1'b0; din = '0; irq_in = 6'h00;
    rd(2'b00, v); chk("rst_imr", v, 32'h00);
    rd(2'b10, v); chk("rst_mode", v, 32'h3F);
    rd(2'b01, v); chk("rst_ipr", v, 32'h00);
    rd(2'b11, v); chk("rst_vec", v, 32'h0);
    chk("rst_intq", {26'd0, intq}, 32'h00);
    chk("rst_any", {31'd0, irq_any}, 32'h0);

    // edge latch and latency
    wr(2'b00, 32'h01);
    irq_in = 6'h01;
    step();
    irq_in = 6'h00;
    rd(2'b01, v); chk("edge_ipr_k", v, 32'h01);
    chk("edge_intq_k", {26'd0, intq}, 32'h00);
    step();
    chk("edge_intq_k1", {26'd0, intq}, 32'h01);
    chk("edge_any_k1", {31'd0, irq_any}, 32'h1);
    rd(2'b11, v); chk("edge_vec", v, 32'h8000_0000);

    // clear while input held high
    irq_in = 6'h01;
    step();
    wr(2'b01, 32'h01);
    rd(2'b01, v); chk("w1c_ipr", v, 32'h00);
    chk("w1c_intq_k", {26'd0, intq}, 32'h01);
    step();
    chk("w1c_intq_k1", {26'd0, intq}, 32'h00);
    step();
    rd(2'b01, v); chk("held_no_reset", v, 32'h00);
    irq_in = 6'h00;

    // set beats clear
    wr(2'b00, 32'h04);
    irq_in = 6'h04;
    wr(2'b01, 32'h04);
    irq_in = 6'h00;
    rd(2'b01, v); chk("sbc_ipr", v, 32'h04);
    step();
    chk("sbc_intq", {26'd0, intq}, 32'h04);
    wr(2'b01, 32'h04);

    // level mode and masking
    wr(2'b10, 32'h00);
    wr(2'b00, 32'h00);
    irq_in = 6'h12;
    step();
    step();
    rd(2'b01, v); chk("lvl_ipr", v, 32'h12);
    chk("lvl_intq_masked", {26'd0, intq}, 32'h00);
    wr(2'b00, 32'h10);
    step();
    chk("lvl_intq_unmask", {26'd0, intq}, 32'h10);
    wr(2'b01, 32'h12);
    rd(2'b01, v); chk("lvl_w1c_noeff", v, 32'h12);
    irq_in = 6'h00;
    step();
    rd(2'b01, v); chk("lvl_drop_ipr", v, 32'h00);
    step();
    chk("lvl_drop_intq", {26'd0, intq}, 32'h00);

    // priority vector
    wr(2'b10, 32'h3F);
    wr(2'b00, 32'h3F);
    irq_in = 6'h2A;
    step();
    irq_in = 6'h00;
    rd(2'b11, v); chk("vec_1", v, 32'h8000_0001);
    wr(2'b01, 32'h02);
    rd(2'b11, v); chk("vec_3", v, 32'h8000_0003);
    wr(2'b01, 32'h08);
    rd(2'b11, v); chk("vec_5", v, 32'h8000_0005);
    rd(2'b01, v); chk("vec_ipr", v, 32'h20);

    // mid-operation reset with a coincident edge
    irq_in = 6'h3F;
    step();
    irq_in = 6'h00;
    step();
    chk("pre_rst_intq", {26'd0, intq}, 32'h3F);
    reset = 1'b0; irq_in = 6'h01;
    step();
    reset = 1'b1; irq_in = 6'h00;
    rd(2'b01, v); chk("mid_rst_ipr", v, 32'h00);
    rd(2'b00, v); chk("mid_rst_imr", v, 32'h00);
    rd(2'b10, v); chk("mid_rst_mode", v, 32'h3F);
    chk("mid_rst_intq", {26'd0, intq}, 32'h00);
    chk("mid_rst_any", {31'd0, irq_any}, 32'h0);
    step();
    rd(2'b01, v); chk("mid_rst_no_latch", v, 32'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/int_ctrl.md
Name: int_ctrl

Overview:
- Memory-mapped interrupt controller on the bridge, alongside timer0/timer1.
- Collects up to N_SRC hardware interrupt lines from peripherals (timer intq outputs and spares).
- Latches them as sticky pending bits under per-source edge/level mode and a mask.
- Drives the CPU's 6-bit intq bus, and exposes a priority-encoded vector register for the exception handler.

Parameters:
- N_SRC, 6, number of interrupt sources; must be 1..6 (CPU intq width).
- RESET_MASK, 6'h00, enable mask loaded at reset (bit i = 1 enables source i).
- RESET_MODE, 6'h3F, mode loaded at reset (1 = rising-edge, 0 = level).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-low reset; sampled on clk rising edge.
- addr  input  [3:2]  register select from bridge.
- we  input  1  write strobe from bridge; one write per cycle it is high.
- din  input  32  write data from bridge.
- dout  output  32  read data, combinational from addr.
- irq_in  input  N_SRC  raw interrupt lines, synchronous to clk.
- intq  output  6  registered masked-pending to CPU; bits above N_SRC-1 are tied 0.
- irq_any  output  1  registered OR of intq.

Behaviour:
- Reset (reset==0 at an edge) loads IMR=RESET_MASK, MODE=RESET_MODE, IPR=0, irq_q=0, intq=0, irq_any=0.
- Reset is honoured mid-operation, overrides any write in the same cycle, and discards pending edges.
- Register map (addr[3:2]):
  - 00 IMR: R/W, bits [N_SRC-1:0].
  - 01 IPR: read pending; write-1-to-clear per bit.
  - 10 MODE: R/W.
  - 11 VEC: read-only. Bit31 = any masked pending; [2:0] = lowest index i with IPR[i]&IMR[i]; all other bits 0. Reads 0 when none pending. Writes ignored.
- Unused upper bits read 0; writes to them are ignored.
- irq_q: registered copy of irq_in, updated every cycle, for edge detection.
- Edge source i (MODE[i]=1): irq_in[i]=1 and irq_q[i]=0 at edge k sets IPR[i] after edge k. The bit stays set until cleared by a W1C write. Held-high input does not re-set the bit after a clear.
- Level source i (MODE[i]=0): IPR[i] follows irq_in[i] each edge; W1C writes have no effect.
- Same-cycle new edge and W1C on the same bit: set wins, IPR[i]=1.
- Masking does not block latching: pending sets even when IMR[i]=0. Unmasking later asserts intq.
- intq[i] <= IPR[i] & IMR[i], registered from post-edge IPR.
  - Latency from irq_in rising (sampled at edge k) to intq high: 2 edges (visible after edge k+1).
  - Latency from W1C at edge k to intq low: visible after edge k+1.
- Writing MODE from 1 to 0 converts the source to level behaviour at the next edge; IPR is overwritten by irq_in.
- Writing MODE from 0 to 1: current IPR is retained; future sets occur on edges only.
- irq_any <= |(IPR & IMR), same timing as intq.
- dout is purely combinational on addr and current register state. A read in the same cycle as a write returns the pre-write value.

Test Plan:
- Reset defaults: drive reset=0 for 2 cycles with irq_in=6'h3F and we=1 → after release IMR=00, MODE=3F, IPR=00, intq=00, irq_any=0.
- Edge latch and latency:
  - Stimulus: write IMR=01; pulse irq_in[0] high for 1 cycle at edge k.
  - Required: IPR=01 after edge k; intq=01 and irq_any=1 after edge k+1; VEC reads 0x80000000.
  - Then: write IPR=01 → intq=00 one edge after the write; holding irq_in[0] high produces no re-set.
- Set-beats-clear: with IPR[2]=0, MODE[2]=1, IMR=04, rising edge on irq_in[2] in the same cycle as W1C din=04 → IPR=04, intq=04 next edge.
- Level mode and masking:
  - Stimulus: MODE=00, IMR=00, irq_in=6'h12.
  - Required: IPR=12, intq=00. Write IMR=10 → intq=10. Drop irq_in → IPR=00, intq=00 one edge later. W1C to IPR has no effect while irq_in=12.
- Priority vector: edge sources 5, 3, 1 pending, IMR=3F → VEC=0x80000001. Clear bit1 → VEC=0x80000003. Clear bit3 → VEC=0x80000005.
- Mid-operation reset: IPR=3F, intq=3F, assert reset for 1 cycle → all state and outputs 0, IMR=RESET_MASK on the next cycle. An irq_in edge coincident with the reset cycle is not latched.
